// File: rtl/arbiter_requester_pair_pkg.sv
// Shared definitions for the four-phase arbiter requester pair.
//
// Holds the per-channel FSM state encoding and the default parameter values
// used by the channel sub-module and the top level.
package arbiter_requester_pair_pkg;

  // Channel FSM states. The encoding is fixed so bench probes and waveform
  // viewers agree on the raw values.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StGranted = 2'd2,
    StRelease = 2'd3
  } req_state_e;

  localparam int unsigned DefaultHoldW      = 8;
  localparam int unsigned DefaultSyncStages = 2;
  localparam int unsigned DefaultTimeout    = 1023;
  localparam int unsigned DefaultToW        = 10;

endpackage

// File: rtl/arbiter_requester_pair_if.sv
// Request/grant bundle between the requester pair and a two-way arbiter.
//
// Signals:
//   R1, R2  request lines, driven by the requester side
//   A1, A2  grant lines, driven by the arbiter side (asynchronous to clk)
// Modports:
//   master  requester side (drives R, samples A)
//   slave   arbiter side (samples R, drives A)
interface arbiter_requester_pair_if;

  logic R1;
  logic R2;
  logic A1;
  logic A2;

  modport master (
    output R1,
    output R2,
    input  A1,
    input  A2
  );

  modport slave (
    input  R1,
    input  R2,
    output A1,
    output A2
  );

endinterface

// File: rtl/arbiter_requester_pair_requester_channel.sv
// One requester channel: turns a single-cycle go pulse into a complete
// four-phase request/grant transaction.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_i      synchronous active-high reset
//   go_i       start pulse; only honoured in idle with the synced grant low
//   hold_i     critical-section length in cycles, captured with go (0 acts as 1)
//   a_i        asynchronous grant from the arbiter
//   req_o      registered request to the arbiter
//   busy_o     channel is not idle
//   in_cs_o    channel owns the resource
//   done_o     one-cycle pulse when the grant release is seen
//   stall_o    sticky: a wait exceeded TIMEOUT, or the grant dropped early
//   grant_s_o  synchronized grant, exported for the mutual-exclusion checker
module arbiter_requester_pair_requester_channel
  import arbiter_requester_pair_pkg::*;
#(
  parameter int unsigned HOLD_W      = DefaultHoldW,
  parameter int unsigned SYNC_STAGES = DefaultSyncStages,
  parameter int unsigned TIMEOUT     = DefaultTimeout,
  parameter int unsigned TO_W        = DefaultToW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              go_i,
  input  logic [HOLD_W-1:0] hold_i,
  input  logic              a_i,
  output logic              req_o,
  output logic              busy_o,
  output logic              in_cs_o,
  output logic              done_o,
  output logic              stall_o,
  output logic              grant_s_o
);

  // Grant synchronizer. Only the last stage is ever looked at.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   grant_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], a_i};
    end
  end

  assign grant_s = sync_q[SYNC_STAGES-1];

  // Channel state.
  req_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [TO_W-1:0]   wait_inc;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              stall_q, stall_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      wait_cnt_q <= '0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      req_q      <= req_d;
      done_q     <= done_d;
      stall_q    <= stall_d;
    end
  end

  // Saturating increment of the wait counter.
  assign wait_inc = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + TO_W'(1);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    wait_cnt_d = wait_cnt_q;
    req_d      = req_q;
    done_d     = 1'b0;
    stall_d    = stall_q;

    unique case (state_q)
      StIdle: begin
        // A grant still high from before a reset must drain before a new
        // request goes out, otherwise the handshake would start mid-phase.
        if (go_i && !grant_s) begin
          state_d    = StReq;
          req_d      = 1'b1;
          hold_cnt_d = (hold_i == '0) ? HOLD_W'(1) : hold_i;
          wait_cnt_d = '0;
        end
      end

      StReq: begin
        if (grant_s) begin
          state_d = StGranted;
        end else begin
          // Keep requesting forever; withdrawing before grant is illegal.
          wait_cnt_d = wait_inc;
          if (wait_inc >= TO_W'(TIMEOUT)) begin
            stall_d = 1'b1;
          end
        end
      end

      StGranted: begin
        // Grant vanishing while we own the resource is an arbiter fault;
        // flag it but finish the transaction normally.
        if (!grant_s) begin
          stall_d = 1'b1;
        end
        if (hold_cnt_q <= HOLD_W'(1)) begin
          state_d    = StRelease;
          req_d      = 1'b0;
          wait_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end

      StRelease: begin
        if (!grant_s) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_inc;
          if (wait_inc >= TO_W'(TIMEOUT)) begin
            stall_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  assign req_o     = req_q;
  assign busy_o    = (state_q != StIdle);
  assign in_cs_o   = (state_q == StGranted);
  assign done_o    = done_q;
  assign stall_o   = stall_q;
  assign grant_s_o = grant_s;

endmodule

// File: rtl/arbiter_requester_pair.sv
// Synchronous client side of a two-way four-phase request/grant arbiter.
//
// Two independent requester channels each run a full request, grant, hold,
// release handshake per go pulse. The top level adds a sticky checker that
// flags any cycle in which both synchronized grants are high.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   go1, go2       per-channel start pulses
//   hold1, hold2   per-channel critical-section length (0 acts as 1)
//   arb            request/grant bundle to the arbiter (R1/R2 out, A1/A2 in)
//   busy1, busy2   channel not idle
//   in_cs1, in_cs2 channel owns the resource
//   done1, done2   one-cycle pulse at the end of each transaction
//   stall1, stall2 sticky wait-timeout / protocol-violation flags
//   mutex_err      sticky: both synchronized grants seen high together
module arbiter_requester_pair
  import arbiter_requester_pair_pkg::*;
#(
  parameter int unsigned HOLD_W      = DefaultHoldW,
  parameter int unsigned SYNC_STAGES = DefaultSyncStages,
  parameter int unsigned TIMEOUT     = DefaultTimeout,
  parameter int unsigned TO_W        = DefaultToW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go1,
  input  logic                     go2,
  input  logic [HOLD_W-1:0]        hold1,
  input  logic [HOLD_W-1:0]        hold2,
  arbiter_requester_pair_if.master arb,
  output logic                     busy1,
  output logic                     busy2,
  output logic                     in_cs1,
  output logic                     in_cs2,
  output logic                     done1,
  output logic                     done2,
  output logic                     stall1,
  output logic                     stall2,
  output logic                     mutex_err
);

  logic g1_s;
  logic g2_s;

  arbiter_requester_pair_requester_channel #(
    .HOLD_W      (HOLD_W),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT),
    .TO_W        (TO_W)
  ) u_ch1 (
    .clk_i     (clk),
    .rst_i     (rst),
    .go_i      (go1),
    .hold_i    (hold1),
    .a_i       (arb.A1),
    .req_o     (arb.R1),
    .busy_o    (busy1),
    .in_cs_o   (in_cs1),
    .done_o    (done1),
    .stall_o   (stall1),
    .grant_s_o (g1_s)
  );

  arbiter_requester_pair_requester_channel #(
    .HOLD_W      (HOLD_W),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT),
    .TO_W        (TO_W)
  ) u_ch2 (
    .clk_i     (clk),
    .rst_i     (rst),
    .go_i      (go2),
    .hold_i    (hold2),
    .a_i       (arb.A2),
    .req_o     (arb.R2),
    .busy_o    (busy2),
    .in_cs_o   (in_cs2),
    .done_o    (done2),
    .stall_o   (stall2),
    .grant_s_o (g2_s)
  );

  // Mutual-exclusion checker. The overlap term is ORed in directly so the
  // flag is visible in the very cycle both synced grants are high; the
  // register keeps it set afterwards. Both inputs are flop outputs.
  logic mutex_q;
  logic overlap;

  assign overlap = g1_s & g2_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      mutex_q <= 1'b0;
    end else if (overlap) begin
      mutex_q <= 1'b1;
    end
  end

  assign mutex_err = mutex_q | overlap;

endmodule

// File: tb/tb_arbiter_requester_pair.sv
module tb_arbiter_requester_pair;

  localparam int SyncStages = 2;
  localparam int Timeout    = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go1 = 1'b0;
  logic       go2 = 1'b0;
  logic [7:0] hold1 = 8'd0;
  logic [7:0] hold2 = 8'd0;
  logic       busy1, busy2, in_cs1, in_cs2, done1, done2, stall1, stall2, mutex_err;

  arbiter_requester_pair_if bus();

  arbiter_requester_pair #(
    .HOLD_W      (8),
    .SYNC_STAGES (SyncStages),
    .TIMEOUT     (Timeout),
    .TO_W        (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .go1       (go1),
    .go2       (go2),
    .hold1     (hold1),
    .hold2     (hold2),
    .arb       (bus),
    .busy1     (busy1),
    .busy2     (busy2),
    .in_cs1    (in_cs1),
    .in_cs2    (in_cs2),
    .done1     (done1),
    .done2     (done2),
    .stall1    (stall1),
    .stall2    (stall2),
    .mutex_err (mutex_err)
  );

  always #5 clk = ~clk;

  // Behavioural four-phase arbiter: answers 1ns after each rising edge,
  // channel 1 wins a tie, a grant is held until its request drops.
  // ovrX lets the bench drive a grant line directly.
  logic g1 = 1'b0, g2 = 1'b0;
  logic ovr1 = 1'b0, ovr2 = 1'b0, a1_ovr = 1'b0, a2_ovr = 1'b0;

  assign bus.A1 = ovr1 ? a1_ovr : g1;
  assign bus.A2 = ovr2 ? a2_ovr : g2;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!bus.R1) g1 = 1'b0;
      if (!bus.R2) g2 = 1'b0;
      if (!g1 && !g2) begin
        if (bus.R1) g1 = 1'b1;
        else if (bus.R2) g2 = 1'b1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: expected critical-section lengths per channel.
  int exp_q1[$];
  int exp_q2[$];

  logic r2_seen = 1'b0;
  logic both_cs_seen = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.R2) r2_seen = 1'b1;
      if (!rst && in_cs1 && in_cs2) both_cs_seen = 1'b1;
    end
  end

  // Per-channel monitor: measures in_cs run length and release-to-done
  // latency, and checks them against the scoreboard whenever done pulses.
  task automatic monitor_ch(input int ch);
    int   run = 0;
    int   since = -1;
    int   exp;
    logic prev_r = 1'b0;
    logic r, cs, dn;
    forever begin
      @(negedge clk);
      r  = (ch == 1) ? bus.R1 : bus.R2;
      cs = (ch == 1) ? in_cs1 : in_cs2;
      dn = (ch == 1) ? done1  : done2;
      if (rst) begin
        run   = 0;
        since = -1;
      end else begin
        if (since >= 0) since++;
        if (prev_r && !r) since = 0;
        if (cs) run++;
        if (dn) begin
          if ((ch == 1 && exp_q1.size() == 0) || (ch == 2 && exp_q2.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL ch%0d unexpected done: got done=1, expected no transaction", ch);
          end else begin
            exp = (ch == 1) ? exp_q1.pop_front() : exp_q2.pop_front();
            check($sformatf("ch%0d in_cs length", ch), run, exp);
            check($sformatf("ch%0d R-fall to done latency", ch), since, SyncStages + 1);
          end
          run   = 0;
          since = -1;
        end
      end
      prev_r = r;
    end
  endtask

  initial monitor_ch(1);
  initial monitor_ch(2);

  task automatic pulse_go(input logic c1, input logic c2, input logic [7:0] h1,
                          input logic [7:0] h2);
    @(negedge clk);
    go1   = c1;
    go2   = c2;
    hold1 = h1;
    hold2 = h2;
    @(negedge clk);
    go1 = 1'b0;
    go2 = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((busy1 || busy2 || exp_q1.size() != 0 || exp_q2.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, " completes within budget"}, int'(n < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  int   n;
  logic seen;

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("reset outputs", int'({bus.R1, bus.R2, busy1, busy2, in_cs1, in_cs2, done1, done2,
                                 stall1, stall2, mutex_err}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single transaction on channel 1, hold 3, plus an ignored go while busy.
    r2_seen = 1'b0;
    exp_q1.push_back(3);
    pulse_go(1'b1, 1'b0, 8'd3, 8'd0);
    check("single R1 after go edge", int'(bus.R1), 1);
    n = 0;
    while (!in_cs1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("single R1-to-in_cs latency", n, SyncStages + 1);
    pulse_go(1'b1, 1'b0, 8'd5, 8'd0);
    wait_idle("single", 100);
    check("single R2/stall1/mutex_err quiet", int'({r2_seen, stall1, mutex_err}), 0);

    // hold = 0 behaves as 1.
    exp_q2.push_back(1);
    pulse_go(1'b0, 1'b1, 8'd0, 8'd0);
    wait_idle("hold0", 100);

    // Contention.
    both_cs_seen = 1'b0;
    exp_q1.push_back(4);
    exp_q2.push_back(2);
    pulse_go(1'b1, 1'b1, 8'd4, 8'd2);
    check("contention both R high", int'({bus.R1, bus.R2}), 3);
    wait_idle("contention", 200);
    check("contention in_cs overlap", int'(both_cs_seen), 0);
    check("contention flags quiet", int'({stall1, stall2, mutex_err}), 0);

    // Stall: grant withheld on channel 1.
    ovr1   = 1'b1;
    a1_ovr = 1'b0;
    exp_q1.push_back(2);
    pulse_go(1'b1, 1'b0, 8'd2, 8'd0);
    n = 0;
    while (!stall1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall1 wait cycles", n, Timeout);
    check("stall R1 still high", int'(bus.R1), 1);
    ovr1 = 1'b0;
    wait_idle("stall recovery", 100);
    check("stall1 sticky", int'(stall1), 1);

    // Mutex fault: both grants forced high for 3 cycles.
    @(negedge clk);
    ovr1 = 1'b1; a1_ovr = 1'b1;
    ovr2 = 1'b1; a2_ovr = 1'b1;
    n = 0;
    while (!mutex_err && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mutex_err latency", n, SyncStages);
    @(negedge clk);
    ovr1 = 1'b0; a1_ovr = 1'b0;
    ovr2 = 1'b0; a2_ovr = 1'b0;
    seen = 1'b1;
    repeat (6) begin
      @(negedge clk);
      seen = seen & mutex_err;
    end
    check("mutex_err sticky", int'(seen), 1);
    check("mutex fault channels idle", int'({busy1, busy2}), 0);

    // Reset in the middle of GRANTED with A1 held high.
    pulse_go(1'b1, 1'b0, 8'd20, 8'd0);
    n = 0;
    while (!in_cs1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reset test reaches GRANTED", int'(n < 20), 1);
    ovr1   = 1'b1;
    a1_ovr = 1'b1;
    rst    = 1'b1;
    @(negedge clk);
    check("after rst R1/busy1/in_cs1/stall1/mutex_err", int'({bus.R1, busy1, in_cs1, stall1,
                                                                mutex_err}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    pulse_go(1'b1, 1'b0, 8'd2, 8'd0);
    seen = 1'b0;
    repeat (4) begin
      seen = seen | busy1;
      @(negedge clk);
    end
    check("go1 dropped while grant high", int'(seen), 0);
    ovr1   = 1'b0;
    a1_ovr = 1'b0;
    repeat (4) @(negedge clk);
    exp_q1.push_back(2);
    pulse_go(1'b1, 1'b0, 8'd2, 8'd0);
    check("go1 accepted after grant drains", int'(busy1), 1);
    wait_idle("post-reset", 100);

    check("scoreboard drained", exp_q1.size() + exp_q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
